// File: rtl/pet_needs_engine.sv
// Pet need counters with scaled-time decay, per-channel boosts and the awake/sleep/critical/dead life cycle.
// Optional PET_AUTOSLEEP_EN: energy (stat 0) reaching zero while awake or critical forces sleep.
module pet_needs_engine #(
   parameter int unsigned NUM_STATS   = 3,
   parameter int unsigned STAT_W      = 3,
   parameter int unsigned TICK_CYCLES = 50_000_000,
   parameter int unsigned DECAY_SECS  = 10,
   parameter int unsigned BOOST_AMT   = 2,
   parameter int unsigned DEATH_SECS  = 30
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_STATS-1:0]        boost,
   input  logic                        sleep_req,
   input  logic                        wake_req,
   input  logic [3:0]                  test_speed,
   output logic [NUM_STATS*STAT_W-1:0] stats,
   output logic [1:0]                  state,
   output logic [3:0]                  face,
   output logic                        sec_pulse
);

   localparam int unsigned MAX   = (1 << STAT_W) - 1;
   localparam int unsigned PRE_W = $clog2(TICK_CYCLES + 1);
   localparam int unsigned DEC_W = $clog2(DECAY_SECS + 1);
   localparam int unsigned DTH_W = $clog2(DEATH_SECS + 1);
   localparam logic [STAT_W-1:0] STAT_MAX  = STAT_W'(MAX);
   localparam logic [STAT_W-1:0] STAT_HALF = STAT_W'(MAX / 2);

   typedef enum logic [1:0] {
      ST_AWAKE = 2'd0,
      ST_SLEEP = 2'd1,
      ST_CRIT  = 2'd2,
      ST_DEAD  = 2'd3
   } pet_state_t;

   pet_state_t        cur_state;
   logic [PRE_W-1:0]  pre_cnt;
   logic [PRE_W-1:0]  eff_shift;
   logic [PRE_W-1:0]  eff_m1;
   logic              pre_term;
   logic [DEC_W-1:0]  dec_cnt;
   logic              decay_tick;
   logic [DTH_W-1:0]  death_cnt;
   logic              death_due;
   logic [STAT_W-1:0] stat_q   [NUM_STATS];
   logic [STAT_W-1:0] stat_nxt [NUM_STATS];
   int                sum      [NUM_STATS];
   logic              boost_ok;
   logic              any_zero;
   logic              all_zero;
   logic              all_high;
   logic [3:0]        face_nxt;

   // Effective period shrinks with test_speed; >= lets a shorter period wrap immediately.
   always_comb begin
      eff_shift = PRE_W'(TICK_CYCLES) >> test_speed;
      eff_m1    = (eff_shift == '0) ? '0 : eff_shift - PRE_W'(1);
      pre_term  = (pre_cnt >= eff_m1);
   end

   // Prescaler and decay timer; decay_tick is coincident with sec_pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt    <= '0;
         sec_pulse  <= 1'b0;
         dec_cnt    <= '0;
         decay_tick <= 1'b0;
      end else begin
         sec_pulse  <= pre_term;
         decay_tick <= 1'b0;
         if (pre_term) begin
            pre_cnt <= '0;
            if (dec_cnt == DEC_W'(DECAY_SECS - 1)) begin
               dec_cnt    <= '0;
               decay_tick <= 1'b1;
            end else begin
               dec_cnt <= dec_cnt + DEC_W'(1);
            end
         end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
         end
      end
   end

   // Saturating per-channel update; energy recovers instead of decaying while asleep.
   always_comb begin
      boost_ok = (cur_state == ST_AWAKE) || (cur_state == ST_CRIT);
      for (int i = 0; i < NUM_STATS; i++) begin
         sum[i] = int'(stat_q[i]);
         if (boost[i] && boost_ok)
            sum[i] = sum[i] + int'(BOOST_AMT);
         if (decay_tick) begin
            if (i == 0 && cur_state == ST_SLEEP)
               sum[i] = sum[i] + 1;
            else
               sum[i] = sum[i] - 1;
         end
         if (cur_state == ST_DEAD)
            stat_nxt[i] = stat_q[i];
         else if (sum[i] < 0)
            stat_nxt[i] = '0;
         else if (sum[i] > int'(MAX))
            stat_nxt[i] = STAT_MAX;
         else
            stat_nxt[i] = STAT_W'(sum[i]);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_STATS; i++) begin
         if (rst) stat_q[i] <= STAT_MAX;
         else     stat_q[i] <= stat_nxt[i];
      end
   end

   always_comb begin
      any_zero = 1'b0;
      all_zero = 1'b1;
      all_high = 1'b1;
      for (int i = 0; i < NUM_STATS; i++) begin
         if (stat_q[i] == '0) any_zero = 1'b1;
         else                 all_zero = 1'b0;
         if (stat_q[i] <= STAT_HALF) all_high = 1'b0;
      end
   end

   always_comb begin
      face_nxt = 4'd1;
      case (cur_state)
         ST_DEAD:  face_nxt = 4'd4;
         ST_SLEEP: face_nxt = 4'd2;
         ST_CRIT:  face_nxt = 4'd3;
         default:  face_nxt = all_high ? 4'd0 : 4'd1;
      endcase
   end

   assign death_due = (cur_state == ST_CRIT) && sec_pulse &&
                      (death_cnt == DTH_W'(DEATH_SECS - 1));

   // Life-cycle FSM on registered stats; DEAD outranks everything and only rst leaves it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state <= ST_AWAKE;
         death_cnt <= '0;
         face      <= 4'd0;
      end else begin
         face <= face_nxt;
         if (cur_state != ST_CRIT)
            death_cnt <= '0;
         else if (sec_pulse)
            death_cnt <= death_cnt + DTH_W'(1);
         if (cur_state != ST_DEAD) begin
            if (all_zero || death_due)
               cur_state <= ST_DEAD;
`ifdef PET_AUTOSLEEP_EN
            else if ((cur_state == ST_AWAKE || cur_state == ST_CRIT) && stat_q[0] == '0)
               cur_state <= ST_SLEEP;
`endif
            else begin
               case (cur_state)
                  ST_AWAKE: begin
                     if (sleep_req)     cur_state <= ST_SLEEP;
                     else if (any_zero) cur_state <= ST_CRIT;
                  end
                  ST_SLEEP: begin
                     if (wake_req || stat_q[0] == STAT_MAX) cur_state <= ST_AWAKE;
                  end
                  ST_CRIT: begin
                     if (sleep_req)      cur_state <= ST_SLEEP;
                     else if (!any_zero) cur_state <= ST_AWAKE;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_STATS; g++) begin : g_pack
      assign stats[g*STAT_W +: STAT_W] = stat_q[g];
   end

   assign state = cur_state;

endmodule

// File: tb/tb_pet_needs_engine.sv
// Directed bench for pet_needs_engine: decay, saturation, sleep, critical/death, reset and acceleration.
module tb_pet_needs_engine;

   logic       clk;
   logic       rst;
   logic [2:0] boost;
   logic       sleep_req;
   logic       wake_req;
   logic [3:0] test_speed;
   logic [8:0] stats;
   logic [1:0] state;
   logic [3:0] face;
   logic       sec_pulse;

   logic [3:0] f_speed;
   logic [8:0] f_stats;
   logic [1:0] f_state;
   logic [3:0] f_face;
   logic       f_sp;

   int n_cmp = 0;
   int n_err = 0;
   int n;

   pet_needs_engine #(
      .NUM_STATS(3), .STAT_W(3), .TICK_CYCLES(4), .DECAY_SECS(2), .BOOST_AMT(2), .DEATH_SECS(3)
   ) u_dut (
      .clk(clk), .rst(rst), .boost(boost), .sleep_req(sleep_req), .wake_req(wake_req),
      .test_speed(test_speed), .stats(stats), .state(state), .face(face), .sec_pulse(sec_pulse)
   );

   pet_needs_engine #(
      .NUM_STATS(3), .STAT_W(3), .TICK_CYCLES(1024), .DECAY_SECS(10), .BOOST_AMT(2), .DEATH_SECS(30)
   ) u_fast (
      .clk(clk), .rst(rst), .boost(3'b000), .sleep_req(1'b0), .wake_req(1'b0),
      .test_speed(f_speed), .stats(f_stats), .state(f_state), .face(f_face), .sec_pulse(f_sp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_edges(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // After return, the next posedge is edge 1 after reset release.
   task automatic do_reset();
      rst = 1'b1;
      wait_edges(1);
      rst = 1'b0;
   endtask

   task automatic pulse_boost(input logic [2:0] b);
      boost = b;
      wait_edges(1);
      boost = 3'b000;
   endtask

   // Edges until the fast instance shows sec_pulse, bounded.
   task automatic count_to_pulse(output int cnt);
      cnt = 0;
      do begin
         wait_edges(1);
         cnt++;
      end while (!f_sp && cnt < 2000);
   endtask

   initial begin
      rst = 1'b1; boost = 3'b000; sleep_req = 1'b0; wake_req = 1'b0;
      test_speed = 4'd0; f_speed = 4'd0;
      wait_edges(3);
      check("rst_stats", 32'(stats), 32'({3'd7, 3'd7, 3'd7}));
      check("rst_state", 32'(state), 32'd0);
      check("rst_face", 32'(face), 32'd0);
      check("rst_sec_pulse", 32'(sec_pulse), 32'd0);
      rst = 1'b0;

      // Decay and coincident boost saturation
      wait_edges(4);
      check("sp_e4", 32'(sec_pulse), 32'd1);
      wait_edges(1);
      check("sp_e5", 32'(sec_pulse), 32'd0);
      wait_edges(3);
      check("sp_e8", 32'(sec_pulse), 32'd1);
      check("stats_e8", 32'(stats), 32'({3'd7, 3'd7, 3'd7}));
      pulse_boost(3'b010);
      check("decay_boost_e9", 32'(stats), 32'({3'd6, 3'd7, 3'd6}));
      wait_edges(24);
      check("stats_e33", 32'(stats), 32'({3'd3, 3'd4, 3'd3}));
      check("face_e33", 32'(face), 32'd0);
      wait_edges(1);
      check("face_e34", 32'(face), 32'd1);

      // Sleep recovery; simultaneous sleep/wake while awake sleeps
      do_reset();
      wait_edges(17);
      sleep_req = 1'b1; wake_req = 1'b1;
      wait_edges(1);
      sleep_req = 1'b0; wake_req = 1'b0;
      check("sleep_state", 32'(state), 32'd1);
      wait_edges(1);
      check("sleep_face", 32'(face), 32'd2);
      pulse_boost(3'b111);
      check("sleep_boost_ignored", 32'(stats), 32'({3'd5, 3'd5, 3'd5}));
      wait_edges(13);
      check("sleep_recover_stats", 32'(stats), 32'({3'd3, 3'd3, 3'd7}));
      check("sleep_still", 32'(state), 32'd1);
      wait_edges(1);
      check("wake_on_full", 32'(state), 32'd0);
      wait_edges(1);
      check("wake_face", 32'(face), 32'd1);

      // Critical, rescue, then death
      do_reset();
      wait_edges(12); pulse_boost(3'b011);
      wait_edges(15); pulse_boost(3'b011);
      wait_edges(15); pulse_boost(3'b011);
      wait_edges(12);
      wait_edges(1);
      check("crit_state", 32'(state), 32'd2);
      pulse_boost(3'b100);
      check("crit_face", 32'(face), 32'd3);
      wait_edges(1);
      check("crit_rescued", 32'(state), 32'd0);
      wait_edges(21);
      check("zero_holds_e81", 32'(stats), 32'({3'd0, 3'd2, 3'd2}));
      wait_edges(3);
      check("crit_e84", 32'(state), 32'd2);
      wait_edges(1);
      check("dead_e85", 32'(state), 32'd3);
      wait_edges(1);
      check("dead_face", 32'(face), 32'd4);
      boost = 3'b111; wake_req = 1'b1;
      wait_edges(1);
      boost = 3'b000; wake_req = 1'b0;
      wait_edges(3);
      check("dead_terminal", 32'(state), 32'd3);
      check("dead_frozen", 32'(stats), 32'({3'd0, 3'd2, 3'd2}));

      // Reset wins over input pulses in the same cycle
      boost = 3'b111; sleep_req = 1'b1; rst = 1'b1;
      wait_edges(1);
      check("midrst_state", 32'(state), 32'd0);
      check("midrst_stats", 32'(stats), 32'({3'd7, 3'd7, 3'd7}));
      check("midrst_face", 32'(face), 32'd0);
      rst = 1'b0; boost = 3'b000; sleep_req = 1'b0;

      // Energy to zero while awake
      wait_edges(12); pulse_boost(3'b110);
      wait_edges(15); pulse_boost(3'b110);
      wait_edges(15); pulse_boost(3'b110);
      wait_edges(12);
      check("energy_zero", 32'(stats), 32'({3'd5, 3'd5, 3'd0}));
      wait_edges(1);
`ifdef PET_AUTOSLEEP_EN
      check("autosleep_state", 32'(state), 32'd1);
`else
      check("autosleep_state", 32'(state), 32'd2);
`endif

      // Acceleration on the 1024-cycle instance
      f_speed = 4'd4;
      do_reset();
      count_to_pulse(n);
      check("speed4_first", 32'(n), 32'd64);
      count_to_pulse(n);
      check("speed4_period", 32'(n), 32'd64);
      f_speed = 4'd15;
      count_to_pulse(n);
      check("speed15_first", 32'(n), 32'd1);
      count_to_pulse(n);
      check("speed15_period", 32'(n), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
